// File: rtl/parking_gate_controller_if.sv
// Lane sensor inputs and gate/status outputs of the parking gate controller.
// The controller connects through slave; the environment that drives the sensors connects through master.
interface parking_gate_controller_if;
  logic       entry_motion;
  logic       exit_motion;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       entry_denied;

  modport master (
    output entry_motion,
    output exit_motion,
    input  entry_gate_open,
    input  exit_gate_open,
    input  occupancy,
    input  full,
    input  empty,
    input  entry_denied
  );

  modport slave (
    input  entry_motion,
    input  exit_motion,
    output entry_gate_open,
    output exit_gate_open,
    output occupancy,
    output full,
    output empty,
    output entry_denied
  );
endinterface

// File: rtl/parking_gate_controller.sv
// Two-lane parking gate controller: per-lane motion debouncer and IDLE/OPEN/HOLD gate FSM,
// shared saturating occupancy counter. Lane index 0 is the entry lane, 1 is the exit lane.
module parking_gate_controller #(
  parameter int CAPACITY  = 4,
  parameter int DEBOUNCE  = 3,
  parameter int OPEN_TIME = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  parking_gate_controller_if.slave  bus
);

  localparam int         CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int         TW  = $clog2(OPEN_TIME + 1);
  localparam logic [3:0] CAP = 4'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } state_e;

  logic [1:0]    raw;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    rise_q, rise_d;
  logic [1:0]    fall_q, fall_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_e        st_q  [2];
  state_e        st_d  [2];
  logic [TW-1:0] tmr_q [2];
  logic [TW-1:0] tmr_d [2];
  logic [1:0]    gate_q, gate_d;
  logic [1:0]    pass;
  logic          denied_q, denied_d;
  logic [3:0]    occ_q, occ_d;
  logic          full;
  logic          empty;

  // Both directions on the same edge cancel; otherwise clamp to 0..CAPACITY.
  function automatic logic [3:0] occ_next(input logic [3:0] occ,
                                          input logic       inc,
                                          input logic       dec);
    logic [3:0] res;
    res = occ;
    if (inc && !dec) begin
      res = (occ >= CAP) ? CAP : occ + 4'd1;
    end else if (dec && !inc) begin
      res = (occ == 4'd0) ? 4'd0 : occ - 4'd1;
    end
    return res;
  endfunction

  assign raw   = {bus.exit_motion, bus.entry_motion};
  assign full  = (occ_q == CAP);
  assign empty = (occ_q == 4'd0);

  // Debounce: a run of DEBOUNCE mismatching samples flips deb; any matching sample restarts the run.
  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int l = 0; l < 2; l++) begin
      if (raw[l] != deb_q[l]) begin
        if (cnt_q[l] == CW'(DEBOUNCE - 1)) begin
          deb_d[l]  = raw[l];
          cnt_d[l]  = '0;
          rise_d[l] = raw[l];
          fall_d[l] = ~raw[l];
        end else begin
          cnt_d[l] = cnt_q[l] + CW'(1);
        end
      end else begin
        cnt_d[l] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int l = 0; l < 2; l++) begin
        cnt_q[l] <= '0;
      end
    end else begin
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int l = 0; l < 2; l++) begin
        cnt_q[l] <= cnt_d[l];
      end
    end
  end

  // Gate FSMs; the full check sees the registered occupancy at the decision edge.
  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q;
    pass     = '0;
    gate_d   = '0;
    denied_d = 1'b0;
    for (int l = 0; l < 2; l++) begin
      unique case (st_q[l])
        IDLE: begin
          if (rise_q[l]) begin
            if (l == 0 && full) begin
              denied_d = 1'b1;
            end else begin
              st_d[l] = OPEN;
            end
          end
        end
        OPEN: begin
          if (fall_q[l]) begin
            st_d[l]  = HOLD;
            tmr_d[l] = TW'(OPEN_TIME);
            pass[l]  = 1'b1;
          end
        end
        HOLD: begin
          if (rise_q[l]) begin
            st_d[l]  = OPEN;
            tmr_d[l] = '0;
          end else if (tmr_q[l] == TW'(1)) begin
            st_d[l]  = IDLE;
            tmr_d[l] = '0;
          end else begin
            tmr_d[l] = tmr_q[l] - TW'(1);
          end
        end
        default: begin
          st_d[l]  = IDLE;
          tmr_d[l] = '0;
        end
      endcase
      gate_d[l] = (st_d[l] != IDLE);
    end
  end

  assign occ_d = occ_next(occ_q, pass[0], pass[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q   <= '0;
      denied_q <= 1'b0;
      occ_q    <= '0;
      for (int l = 0; l < 2; l++) begin
        st_q[l]  <= IDLE;
        tmr_q[l] <= '0;
      end
    end else begin
      gate_q   <= gate_d;
      denied_q <= denied_d;
      occ_q    <= occ_d;
      for (int l = 0; l < 2; l++) begin
        st_q[l]  <= st_d[l];
        tmr_q[l] <= tmr_d[l];
      end
    end
  end

  assign bus.entry_gate_open = gate_q[0];
  assign bus.exit_gate_open  = gate_q[1];
  assign bus.occupancy       = occ_q;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.entry_denied    = denied_q;

endmodule
